// File: rtl/bus_arb_pkg.sv
// Shared levels and helpers for the round-robin bus arbiter.
// Grant/request/lock pins are active-low; reset is active-low.
package bus_arb_pkg;

  localparam logic ENABLE       = 1'b0;
  localparam logic DISABLE      = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;

  function automatic int mod_inc(
    input int idx,
    input int n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: first active request from start upward,
// wrapping modulo N, never choosing the excluded index.
import bus_arb_pkg::*;

module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic [W-1:0] excl,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = start;
    for (int i = 0; i < N; i++) begin
      if (!found && req[idx] && idx != excl) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = W'(mod_inc(32'(idx), N));
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with parked grant and owner index.
// Define BUS_ARB_TENURE_EN to preempt long contended tenures.
import bus_arb_pkg::*;

module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = $clog2(NUM_MASTERS),
  parameter int MAX_TENURE  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_,
  input  logic [NUM_MASTERS-1:0] lock_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   handover
);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] others;
  logic [OWNER_W-1:0]     start;
  logic [OWNER_W-1:0]     winner;
  logic [OWNER_W-1:0]     owner_nxt;
  logic                   found;
  logic                   own_req;
  logic                   contention;
  logic                   preempt;

  assign req   = ~req_;
  assign start = OWNER_W'(mod_inc(32'(owner), NUM_MASTERS));

  always_comb begin
    others        = req;
    others[owner] = 1'b0;
  end

  assign own_req    = req[owner];
  assign contention = |others;

  rr_pick #(
    .N (NUM_MASTERS),
    .W (OWNER_W)
  ) u_pick (
    .req    (req),
    .start  (start),
    .excl   (owner),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    owner_nxt = owner;
    if (!(own_req && !preempt) && found)
      owner_nxt = winner;
  end

  always_comb begin
    grnt_        = {NUM_MASTERS{DISABLE}};
    grnt_[owner] = ENABLE;
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE) begin
      owner    <= '0;
      handover <= 1'b0;
    end else begin
      owner    <= owner_nxt;
      handover <= (owner_nxt != owner);
    end
  end

`ifdef BUS_ARB_TENURE_EN
  localparam int TEN_W = $clog2(MAX_TENURE);
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);

  logic [TEN_W-1:0] tenure;
  logic [TEN_W-1:0] tenure_nxt;
  logic             holds;

  assign preempt = (tenure == TEN_LAST) && contention
                   && (lock_[owner] == DISABLE);
  assign holds   = (owner_nxt == owner) && contention;

  // Saturates while locked; cleared on any handover or idle edge.
  always_comb begin
    tenure_nxt = '0;
    if (holds)
      tenure_nxt = (tenure == TEN_LAST) ? tenure : tenure + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE)
      tenure <= '0;
    else
      tenure <= tenure_nxt;
  end
`else
  logic cfg_unused;

  assign preempt    = 1'b0;
  assign cfg_unused = ^lock_ ^ (MAX_TENURE == 0);
`endif

endmodule
